keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 matrix keypad, synchronizes and debounces the column lines, and emits a one-cycle `key_pressed` strobe with a stable 4-bit `key_code`. It sits directly upstream of the calculator FSM, which registers `key_code` and the strobe and decodes digits, operators, CE (`*`) and equal (`#`). Codes are `{row[1:0], col[1:0]}`:
- Row 0: 1, 2, 3, A
- Row 1: 4, 5, 6, B
- Row 2: 7, 8, 9, C
- Row 3: \*, 0, #, D

So `1`=4'b0000, `5`=4'b0101, `0`=4'b1101, `*`=4'b1100, `#`=4'b1110, `D`=4'b1111.

## Interface
- `SCAN_DIV`, 12000: clock cycles each row is driven (dwell). Must be ≥ 4.
- `DEBOUNCE`, 4: consecutive matching full scans (frames) required to accept a press or a release. Must be ≥ 2.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset_in` in 1: synchronous, active-high reset.
- `row_out` out 4: row drive, active-low one-hot; bit r low selects row r.
- `col_in` in 4: column sense, active-low (pulled up externally), asynchronous.
- `key_code` out 4: `{row,col}` of the last accepted key; held until the next accepted press.
- `key_pressed` out 1: one-cycle strobe on each accepted press.
- `key_held` out 1: level; high from acceptance until the release is debounced.

## Operation
- **Synchronizer:** `col_in` passes through 2 flops. Both reset to 4'b1111.
- **Scanner:**
  - Row index r cycles 0,1,2,3,0,… and `row_out` = ~(1<<r).
  - A dwell counter runs 0..SCAN_DIV-1.
  - On dwell cycle SCAN_DIV-1, the synchronized columns are sampled and r advances.
  - A frame is 4 dwells; "frame end" is the sample cycle of row 3.
- **Frame hit:**
  - The first low column found in scan order (row ascending, then column ascending) sets `hit` and `cand_code` for the frame.
  - Any later keys in the same frame are ignored, so multi-key gives the lowest code.
  - `hit` and `cand_code` clear at the start of each frame.
- **Debounce FSM**, evaluated only at frame end:
  - IDLE:
    - hit → PRESS, `pend`=`cand_code`, `cnt`=1.
    - no hit → stay.
  - PRESS:
    - hit with code == `pend` → `cnt`+1; if the new `cnt` == DEBOUNCE → HELD, set `key_code`=`pend`, pulse `key_pressed`, set `key_held`=1.
    - hit with a different code → `pend`=new code, `cnt`=1.
    - no hit → IDLE.
  - HELD:
    - no hit → RELEASE, `cnt`=1.
    - any hit → stay. A second key while held produces no new press.
  - RELEASE:
    - hit → HELD, with no pulse.
    - no hit → `cnt`+1; if `cnt` == DEBOUNCE → IDLE and `key_held`=0.
- Counter widths: dwell is $clog2(SCAN_DIV); `cnt` is $clog2(DEBOUNCE+1). No wrap is possible because the FSM exits at DEBOUNCE.
- A press requires a release to be debounced before the same or another key can strobe again.

## Timing
- **Reset values:** `row_out`=4'b1110, `key_code`=4'b0000, `key_pressed`=0, `key_held`=0, r=0, dwell=0, `cnt`=0, state IDLE, `hit`=0.
- **Reset mid-operation** returns to these values on the next edge. It aborts any pending press with no strobe; a held key must then be re-debounced.
- **Latency:**
  - The synchronizer adds 2 cycles, so a column change must be stable for ≥2 cycles before the sample cycle.
  - `key_pressed`, `key_code` and `key_held` are all registered and update on the same edge: the cycle after the DEBOUNCE-th consecutive matching frame end.
  - Minimum press-to-strobe: DEBOUNCE frames = DEBOUNCE·4·SCAN_DIV cycles, plus up to 1 frame of alignment.
- **Strobe:**
  - `key_pressed` is high exactly 1 cycle and never on consecutive cycles.
  - `key_code` is valid on the strobe cycle and stays stable afterwards, which the downstream stage relies on.
- **Simultaneous events:**
  - Reset has priority over everything.
  - A frame end coinciding with a code change in PRESS takes the new code with `cnt`=1.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE=3 (frame = 16 cycles); a keypad model drives `col_in[c]` low while `row_out[r]` is low for the pressed key.
- **Reset/scan:** assert `reset_in` 3 cycles → `row_out`=1110, outputs 0. Release reset → `row_out` sequence 1110,1101,1011,0111 with 4 cycles each, repeating.
- **Clean press:** hold `5` for 10 frames → exactly one `key_pressed` pulse with `key_code`=0101, 3–4 frames after press. `key_held`=1 until 3 frames after release, then 0.
- **Bounce:** toggle `0` present/absent on alternate frames for 12 frames → no `key_pressed`, `key_code` stays 0000. A subsequent steady `0` for 4 frames → one pulse with `key_code`=1101.
- **Multi-key:** hold `1` and `D` together → one pulse, `key_code`=0000. Then release `1` while `D` stays held → no new pulse; release `D` and re-press `D` → pulse with `key_code`=1111.
- **Release glitch:** while `#` is held (`key_held`=1), remove it for 1 frame then restore → `key_held` stays 1 and no second pulse. A full release of 3 frames → `key_held`=0.
- **Reset mid-press:** press `*`, assert reset after 2 frames (during PRESS) → no strobe. Keep `*` held after reset → pulse with `key_code`=1100 only after 3 fresh frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows one at a time, synchronizes the column
// lines and debounces whole-keypad frames before emitting a one-cycle key strobe.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 12000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_in,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DwellLast = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CntDone = CW'(DEBOUNCE);

    typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} state_e;

    logic [3:0]    col_meta_q, col_sync_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_q;
    logic          hit_q;
    logic [3:0]    cand_q;
    state_e        state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    key_code_q, key_code_d;
    logic          pressed_q, pressed_d;
    logic          held_q, held_d;

    logic       sample, frame_end, row_hit, frame_hit;
    logic [1:0] col_idx;
    logic [3:0] frame_code;

    assign sample    = (dwell_q == DwellLast);
    assign frame_end = sample && (row_q == 2'd3);
    assign row_hit   = ~&col_sync_q;

    // Lowest-numbered low column wins so multi-key presses resolve to the lowest code.
    always_comb begin
        col_idx = 2'd0;
        if (!col_sync_q[0])      col_idx = 2'd0;
        else if (!col_sync_q[1]) col_idx = 2'd1;
        else if (!col_sync_q[2]) col_idx = 2'd2;
        else if (!col_sync_q[3]) col_idx = 2'd3;
    end

    // Row 3 is sampled on the frame-end cycle itself, so fold it in combinationally.
    assign frame_hit  = hit_q | row_hit;
    assign frame_code = hit_q ? cand_q : {row_q, col_idx};

    always_ff @(posedge clk) begin
        if (reset_in) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
            dwell_q    <= '0;
            row_q      <= 2'd0;
            hit_q      <= 1'b0;
            cand_q     <= 4'b0000;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
            if (sample) begin
                dwell_q <= '0;
                row_q   <= row_q + 2'd1;
                if (frame_end) begin
                    hit_q  <= 1'b0;
                    cand_q <= 4'b0000;
                end else if (!hit_q && row_hit) begin
                    hit_q  <= 1'b1;
                    cand_q <= {row_q, col_idx};
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        key_code_d = key_code_q;
        pressed_d  = 1'b0;
        held_d     = held_q;
        cnt_inc    = cnt_q + CW'(1);
        if (frame_end) begin
            case (state_q)
                StIdle: begin
                    if (frame_hit) begin
                        state_d = StPress;
                        pend_d  = frame_code;
                        cnt_d   = CW'(1);
                    end
                end
                StPress: begin
                    if (!frame_hit) begin
                        state_d = StIdle;
                    end else if (frame_code == pend_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntDone) begin
                            state_d    = StHeld;
                            key_code_d = pend_q;
                            pressed_d  = 1'b1;
                            held_d     = 1'b1;
                        end
                    end else begin
                        pend_d = frame_code;
                        cnt_d  = CW'(1);
                    end
                end
                StHeld: begin
                    if (!frame_hit) begin
                        state_d = StRelease;
                        cnt_d   = CW'(1);
                    end
                end
                StRelease: begin
                    if (frame_hit) begin
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntDone) begin
                            state_d = StIdle;
                            held_d  = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q    <= StIdle;
            pend_q     <= 4'b0000;
            cnt_q      <= '0;
            key_code_q <= 4'b0000;
            pressed_q  <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            key_code_q <= key_code_d;
            pressed_q  <= pressed_d;
            held_q     <= held_d;
        end
    end

    assign row_out     = ~(4'b0001 << row_q);
    assign key_code    = key_code_q;
    assign key_pressed = pressed_q;
    assign key_held    = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes row/column contacts, a frame-level
// model predicts outputs every cycle, and directed scenarios pin literal results.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic [3:0] row_out;
    logic [3:0] col_in;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_held;
    logic [15:0] keys = '0;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .row_out    (row_out),
        .col_in     (col_in),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row_out[r] == 1'b0)) col_in[c] = 1'b0;
    end

    // Frame-level model: keys only change on frame boundaries, so each frame sees one
    // key set; the visible key is the lowest pressed code.
    int         n = 0;
    bit         model_on = 1'b0;
    bit         m_held = 1'b0;
    int         run_code = 0, run_len = 0, miss_len = 0, f_code = -1;
    logic [3:0] m_code = 4'b0000;
    logic       m_pulse = 1'b0;
    logic [3:0] m_row = 4'b1110;

    always @(posedge clk) begin
        m_pulse = 1'b0;
        if (reset_in) begin
            n        = 0;
            model_on = 1'b1;
            m_held   = 1'b0;
            run_len  = 0;
            miss_len = 0;
            m_code   = 4'b0000;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                f_code = -1;
                for (int k = 0; k < 16; k++) if (keys[k] && f_code < 0) f_code = k;
                if (!m_held) begin
                    if (f_code >= 0) begin
                        if (run_len > 0 && f_code == run_code) run_len++;
                        else begin
                            run_code = f_code;
                            run_len  = 1;
                        end
                        if (run_len == DEBOUNCE) begin
                            m_held   = 1'b1;
                            m_pulse  = 1'b1;
                            m_code   = 4'(run_code);
                            miss_len = 0;
                        end
                    end else begin
                        run_len = 0;
                    end
                end else if (f_code >= 0) begin
                    miss_len = 0;
                end else begin
                    miss_len++;
                    if (miss_len == DEBOUNCE) begin
                        m_held  = 1'b0;
                        run_len = 0;
                    end
                end
            end
        end
        m_row = ~(4'b0001 << ((n / SCAN_DIV) % 4));
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("row_out", row_out, m_row);
            check("key_code", key_code, m_code);
            check("key_pressed", {3'b000, key_pressed}, {3'b000, m_pulse});
            check("key_held", {3'b000, key_held}, {3'b000, m_held});
        end
        if (key_pressed === 1'b1) pulses++;
    end

    task automatic apply_reset();
        reset_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_in = 1'b0;
    endtask

    task automatic frames(input int k);
        repeat (k * FRAME) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values and scan order
        reset_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row", row_out, 4'b1110);
        check("rst_code", key_code, 4'b0000);
        check("rst_pressed", {3'b000, key_pressed}, 4'b0000);
        check("rst_held", {3'b000, key_held}, 4'b0000);
        reset_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("scan_row1", row_out, 4'b1101);
        repeat (4) @(posedge clk);
        #1 check("scan_row2", row_out, 4'b1011);
        repeat (4) @(posedge clk);
        #1 check("scan_row3", row_out, 4'b0111);
        repeat (4) @(posedge clk);
        #1 check("scan_wrap", row_out, 4'b1110);

        // Clean press of 5
        pulses = 0;
        keys[5] = 1'b1;
        frames(2);
        check("clean_early", {3'b000, key_pressed}, 4'b0000);
        frames(1);
        check("clean_strobe", {3'b000, key_pressed}, 4'b0001);
        check("clean_code", key_code, 4'b0101);
        check("clean_held", {3'b000, key_held}, 4'b0001);
        frames(7);
        keys = '0;
        frames(2);
        check("clean_still_held", {3'b000, key_held}, 4'b0001);
        frames(1);
        check("clean_released", {3'b000, key_held}, 4'b0000);
        check_int("clean_pulses", pulses, 1);

        // Bouncing 0 followed by a steady 0
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            keys[13] = (i % 2 == 0);
            frames(1);
        end
        check_int("bounce_pulses", pulses, 0);
        check("bounce_code", key_code, 4'b0000);
        keys[13] = 1'b1;
        frames(4);
        check_int("steady_pulses", pulses, 1);
        check("steady_code", key_code, 4'b1101);

        // Multi-key: 1 and D together
        apply_reset();
        keys = '0;
        pulses = 0;
        keys[0] = 1'b1;
        keys[15] = 1'b1;
        frames(4);
        check_int("multi_pulses", pulses, 1);
        check("multi_code", key_code, 4'b0000);
        keys[0] = 1'b0;
        frames(3);
        check_int("multi_no_repress", pulses, 1);
        check("multi_held", {3'b000, key_held}, 4'b0001);
        keys[15] = 1'b0;
        frames(3);
        check("multi_released", {3'b000, key_held}, 4'b0000);
        keys[15] = 1'b1;
        frames(3);
        check("d_strobe", {3'b000, key_pressed}, 4'b0001);
        check("d_code", key_code, 4'b1111);
        frames(1);
        check_int("d_pulses", pulses, 2);

        // Release glitch on #
        apply_reset();
        keys = '0;
        pulses = 0;
        keys[14] = 1'b1;
        frames(4);
        check("hash_code", key_code, 4'b1110);
        keys[14] = 1'b0;
        frames(1);
        keys[14] = 1'b1;
        frames(3);
        check("glitch_held", {3'b000, key_held}, 4'b0001);
        check_int("glitch_pulses", pulses, 1);
        keys = '0;
        frames(2);
        check("glitch_rel_wait", {3'b000, key_held}, 4'b0001);
        frames(1);
        check("glitch_released", {3'b000, key_held}, 4'b0000);

        // Reset in the middle of a press of *
        apply_reset();
        pulses = 0;
        keys[12] = 1'b1;
        frames(2);
        apply_reset();
        frames(2);
        check_int("midrst_pulses", pulses, 0);
        check("midrst_early", {3'b000, key_pressed}, 4'b0000);
        frames(1);
        check("midrst_strobe", {3'b000, key_pressed}, 4'b0001);
        check("midrst_code", key_code, 4'b1100);
        frames(1);
        check_int("midrst_total", pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
